// File: rtl/rv_decode_stage.sv
// ---------------------------------------------------------------------------
// fe_pkg / rv_decode_stage
//
// Purpose:
//   Front-end RV32I / RV32IM instruction decode stage.
//   - Raw instruction words arrive with their PC over a valid/ready handshake.
//   - Each word is decoded combinationally into register addresses, a
//     sign-extended immediate, the opcode and a mnemonic, and the result is
//     pushed into a small circular queue.
//   - The queue lets fetch keep running while the consumer stalls.
//   - flush empties the queue when fetch is redirected.
//
// Parameters:
//   XLEN        datapath width (32 or 64), sizes PC and immediate
//   QUEUE_DEPTH buffered entries, power of two, >= 2
//   EN_M        1 = decode RV32M, 0 = RV32M encodings are illegal
//
// Ports:
//   clk, rst                 rising-edge clock, async active-high reset
//   flush                    drop every queued entry (beats push and pop)
//   in_valid/in_ready        input handshake; in_ready = occupancy < depth
//   in_instr, in_pc          raw instruction word and its PC
//   out_valid/out_ready      output handshake on the head entry
//   out_pc, out_rs1, out_rs2, out_rd, out_imm, out_opcode, out_mnemonic,
//   out_illegal              head entry fields, all zero / NULL when empty
//   occupancy                number of entries currently held
// ---------------------------------------------------------------------------

package fe_pkg;

    typedef enum logic [6:0] {
        OPC_LOAD     = 7'b0000011,
        OPC_MISC_MEM = 7'b0001111,
        OPC_OP_IMM   = 7'b0010011,
        OPC_AUIPC    = 7'b0010111,
        OPC_STORE    = 7'b0100011,
        OPC_OP       = 7'b0110011,
        OPC_LUI      = 7'b0110111,
        OPC_BRANCH   = 7'b1100011,
        OPC_JALR     = 7'b1100111,
        OPC_JAL      = 7'b1101111,
        OPC_SYSTEM   = 7'b1110011
    } RV32I_OPCODE_t;

    typedef logic [4:0] RV32I_REGISTER_t;

    // NULL is encoded as zero so an empty output reads as all-zero.
    typedef enum logic [5:0] {
        NULL = 6'd0,
        LUI, AUIPC, JAL, JALR,
        BEQ, BNE, BLT, BGE, BLTU, BGEU,
        LB, LH, LW, LBU, LHU,
        SB, SH, SW,
        ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
        FENCE, ECALL, EBREAK,
        MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
    } RV32I_INSTRUCTION_MNEMONIC_t;

endpackage

module rv_decode_stage
    import fe_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned QUEUE_DEPTH = 2,
    parameter bit          EN_M        = 1'b1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 flush,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [31:0]                          in_instr,
    input  logic [XLEN-1:0]                      in_pc,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [XLEN-1:0]                      out_pc,
    output RV32I_REGISTER_t                      out_rs1,
    output RV32I_REGISTER_t                      out_rs2,
    output RV32I_REGISTER_t                      out_rd,
    output logic [XLEN-1:0]                      out_imm,
    output RV32I_OPCODE_t                        out_opcode,
    output RV32I_INSTRUCTION_MNEMONIC_t          out_mnemonic,
    output logic                                 out_illegal,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]     occupancy
);

    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);

    typedef struct packed {
        logic [XLEN-1:0]             pc;
        RV32I_REGISTER_t             rs1;
        RV32I_REGISTER_t             rs2;
        RV32I_REGISTER_t             rd;
        logic [XLEN-1:0]             imm;
        RV32I_OPCODE_t               opcode;
        RV32I_INSTRUCTION_MNEMONIC_t mnemonic;
        logic                        illegal;
    } entry_t;

    // -----------------------------------------------------------------------
    // Combinational decode of the incoming word
    // -----------------------------------------------------------------------
    logic [6:0]  opc;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign opc    = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                    in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u = {in_instr[31:12], 12'b0};
    assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                    in_instr[20], in_instr[30:21], 1'b0};

    RV32I_INSTRUCTION_MNEMONIC_t dec_mnemonic;
    logic                        use_rs1;
    logic                        use_rs2;
    logic                        use_rd;
    logic [31:0]                 dec_imm32;
    logic                        dec_legal;
    entry_t                      new_entry;

    // Every legal encoding gets a mnemonic other than NULL, so legality is
    // simply "a mnemonic was found". Anything that falls through stays NULL.
    always_comb begin
        dec_mnemonic = NULL;
        use_rs1      = 1'b0;
        use_rs2      = 1'b0;
        use_rd       = 1'b0;
        dec_imm32    = '0;
        if (in_instr[1:0] == 2'b11) begin
            case (opc)
                OPC_LUI: begin
                    dec_mnemonic = LUI;
                    use_rd       = 1'b1;
                    dec_imm32    = imm_u;
                end
                OPC_AUIPC: begin
                    dec_mnemonic = AUIPC;
                    use_rd       = 1'b1;
                    dec_imm32    = imm_u;
                end
                OPC_JAL: begin
                    dec_mnemonic = JAL;
                    use_rd       = 1'b1;
                    dec_imm32    = imm_j;
                end
                OPC_JALR: begin
                    use_rs1   = 1'b1;
                    use_rd    = 1'b1;
                    dec_imm32 = imm_i;
                    if (funct3 == 3'd0) dec_mnemonic = JALR;
                end
                OPC_BRANCH: begin
                    use_rs1   = 1'b1;
                    use_rs2   = 1'b1;
                    dec_imm32 = imm_b;
                    case (funct3)
                        3'd0:    dec_mnemonic = BEQ;
                        3'd1:    dec_mnemonic = BNE;
                        3'd4:    dec_mnemonic = BLT;
                        3'd5:    dec_mnemonic = BGE;
                        3'd6:    dec_mnemonic = BLTU;
                        3'd7:    dec_mnemonic = BGEU;
                        default: dec_mnemonic = NULL;
                    endcase
                end
                OPC_LOAD: begin
                    use_rs1   = 1'b1;
                    use_rd    = 1'b1;
                    dec_imm32 = imm_i;
                    case (funct3)
                        3'd0:    dec_mnemonic = LB;
                        3'd1:    dec_mnemonic = LH;
                        3'd2:    dec_mnemonic = LW;
                        3'd4:    dec_mnemonic = LBU;
                        3'd5:    dec_mnemonic = LHU;
                        default: dec_mnemonic = NULL;
                    endcase
                end
                OPC_STORE: begin
                    use_rs1   = 1'b1;
                    use_rs2   = 1'b1;
                    dec_imm32 = imm_s;
                    case (funct3)
                        3'd0:    dec_mnemonic = SB;
                        3'd1:    dec_mnemonic = SH;
                        3'd2:    dec_mnemonic = SW;
                        default: dec_mnemonic = NULL;
                    endcase
                end
                OPC_OP_IMM: begin
                    use_rs1   = 1'b1;
                    use_rd    = 1'b1;
                    dec_imm32 = imm_i;
                    // Shift-immediates reuse the top imm bits as a funct7 field.
                    case (funct3)
                        3'd0: dec_mnemonic = ADDI;
                        3'd2: dec_mnemonic = SLTI;
                        3'd3: dec_mnemonic = SLTIU;
                        3'd4: dec_mnemonic = XORI;
                        3'd6: dec_mnemonic = ORI;
                        3'd7: dec_mnemonic = ANDI;
                        3'd1: if (funct7 == 7'b0000000) dec_mnemonic = SLLI;
                        3'd5: begin
                            if (funct7 == 7'b0000000)      dec_mnemonic = SRLI;
                            else if (funct7 == 7'b0100000) dec_mnemonic = SRAI;
                        end
                        default: dec_mnemonic = NULL;
                    endcase
                end
                OPC_OP: begin
                    use_rs1 = 1'b1;
                    use_rs2 = 1'b1;
                    use_rd  = 1'b1;
                    case (funct7)
                        7'b0000000: begin
                            case (funct3)
                                3'd0:    dec_mnemonic = ADD;
                                3'd1:    dec_mnemonic = SLL;
                                3'd2:    dec_mnemonic = SLT;
                                3'd3:    dec_mnemonic = SLTU;
                                3'd4:    dec_mnemonic = XOR;
                                3'd5:    dec_mnemonic = SRL;
                                3'd6:    dec_mnemonic = OR;
                                default: dec_mnemonic = AND;
                            endcase
                        end
                        7'b0100000: begin
                            if (funct3 == 3'd0)      dec_mnemonic = SUB;
                            else if (funct3 == 3'd5) dec_mnemonic = SRA;
                        end
                        7'b0000001: begin
                            if (EN_M) begin
                                case (funct3)
                                    3'd0:    dec_mnemonic = MUL;
                                    3'd1:    dec_mnemonic = MULH;
                                    3'd2:    dec_mnemonic = MULHSU;
                                    3'd3:    dec_mnemonic = MULHU;
                                    3'd4:    dec_mnemonic = DIV;
                                    3'd5:    dec_mnemonic = DIVU;
                                    3'd6:    dec_mnemonic = REM;
                                    default: dec_mnemonic = REMU;
                                endcase
                            end
                        end
                        default: dec_mnemonic = NULL;
                    endcase
                end
                OPC_MISC_MEM: begin
                    use_rs1   = 1'b1;
                    use_rd    = 1'b1;
                    dec_imm32 = imm_i;
                    if (funct3 == 3'd0) dec_mnemonic = FENCE;
                end
                OPC_SYSTEM: begin
                    // Only the two exact ECALL / EBREAK words are accepted.
                    use_rs1   = 1'b1;
                    use_rd    = 1'b1;
                    dec_imm32 = imm_i;
                    if (in_instr == 32'h0000_0073)      dec_mnemonic = ECALL;
                    else if (in_instr == 32'h0010_0073) dec_mnemonic = EBREAK;
                end
                default: dec_mnemonic = NULL;
            endcase
        end
    end

    assign dec_legal = (dec_mnemonic != NULL);

    // Illegal words keep only opcode and PC; everything else is zeroed.
    always_comb begin
        new_entry          = '0;
        new_entry.pc       = in_pc;
        new_entry.opcode   = RV32I_OPCODE_t'(in_instr[6:0]);
        new_entry.mnemonic = dec_mnemonic;
        new_entry.illegal  = !dec_legal;
        if (dec_legal) begin
            new_entry.rs1 = use_rs1 ? in_instr[19:15] : 5'd0;
            new_entry.rs2 = use_rs2 ? in_instr[24:20] : 5'd0;
            new_entry.rd  = use_rd  ? in_instr[11:7]  : 5'd0;
            new_entry.imm = XLEN'($signed(dec_imm32));
        end
    end

    // -----------------------------------------------------------------------
    // Circular queue control
    // -----------------------------------------------------------------------
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             push;
    logic             pop;
    entry_t           mem_q [QUEUE_DEPTH];
    entry_t           head;

    // in_ready depends on registered count only, so out_ready never reaches
    // it combinationally; a pop while full frees space one cycle later.
    assign in_ready  = (count_q < CNT_W'(QUEUE_DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign occupancy = count_q;

    // Next-state for pointers and count. Depth is a power of two, so the
    // pointers wrap modulo depth by plain overflow. Flush wins over both.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: a slot is only visible once count covers it.
    // A non-full queue never writes the head slot, so a stalled head holds.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= new_entry;
        end
    end

    // -----------------------------------------------------------------------
    // Output side: head entry, forced to zero / NULL while empty
    // -----------------------------------------------------------------------
    assign head = mem_q[rd_ptr_q];

    always_comb begin
        out_pc       = '0;
        out_rs1      = '0;
        out_rs2      = '0;
        out_rd       = '0;
        out_imm      = '0;
        out_opcode   = RV32I_OPCODE_t'(7'd0);
        out_mnemonic = NULL;
        out_illegal  = 1'b0;
        if (out_valid) begin
            out_pc       = head.pc;
            out_rs1      = head.rs1;
            out_rs2      = head.rs2;
            out_rd       = head.rd;
            out_imm      = head.imm;
            out_opcode   = head.opcode;
            out_mnemonic = head.mnemonic;
            out_illegal  = head.illegal;
        end
    end

endmodule

// File: tb/tb_rv_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_rv_decode_stage
//
// Purpose:
//   Directed bench for rv_decode_stage. One instance has RV32M enabled, a
//   second one (sharing all inputs) has it disabled. Each task drives one
//   scenario and compares outputs against hand-computed values.
// ---------------------------------------------------------------------------
module tb_rv_decode_stage;
    import fe_pkg::*;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        inValid;
    logic [31:0] inInstr;
    logic [31:0] inPc;
    logic        outReady;

    logic                        inReady;
    logic                        outValid;
    logic [31:0]                 outPc;
    RV32I_REGISTER_t             outRs1, outRs2, outRd;
    logic [31:0]                 outImm;
    RV32I_OPCODE_t               outOpcode;
    RV32I_INSTRUCTION_MNEMONIC_t outMnemonic;
    logic                        outIllegal;
    logic [1:0]                  occupancy;

    logic                        nomInReady;
    logic                        nomOutValid;
    logic [31:0]                 nomOutPc;
    RV32I_REGISTER_t             nomRs1, nomRs2, nomRd;
    logic [31:0]                 nomImm;
    RV32I_OPCODE_t               nomOpcode;
    RV32I_INSTRUCTION_MNEMONIC_t nomMnemonic;
    logic                        nomIllegal;
    logic [1:0]                  nomOccupancy;

    int checks   = 0;
    int failures = 0;

    rv_decode_stage #(.XLEN(32), .QUEUE_DEPTH(2), .EN_M(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(inValid), .in_ready(inReady), .in_instr(inInstr), .in_pc(inPc),
        .out_valid(outValid), .out_ready(outReady), .out_pc(outPc),
        .out_rs1(outRs1), .out_rs2(outRs2), .out_rd(outRd), .out_imm(outImm),
        .out_opcode(outOpcode), .out_mnemonic(outMnemonic),
        .out_illegal(outIllegal), .occupancy(occupancy)
    );

    rv_decode_stage #(.XLEN(32), .QUEUE_DEPTH(2), .EN_M(1'b0)) dutNoM (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(inValid), .in_ready(nomInReady), .in_instr(inInstr), .in_pc(inPc),
        .out_valid(nomOutValid), .out_ready(outReady), .out_pc(nomOutPc),
        .out_rs1(nomRs1), .out_rs2(nomRs2), .out_rd(nomRd), .out_imm(nomImm),
        .out_opcode(nomOpcode), .out_mnemonic(nomMnemonic),
        .out_illegal(nomIllegal), .occupancy(nomOccupancy)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge, where outputs are settled
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; inValid = 1'b0; inInstr = '0; inPc = '0; outReady = 1'b0;
        tick();
        tick();
        checks++; if (outValid !== 1'b0) begin failures++; $display("FAIL reset_out_valid actual=%0b expected=0", outValid); end
        checks++; if (inReady !== 1'b1) begin failures++; $display("FAIL reset_in_ready actual=%0b expected=1", inReady); end
        checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL reset_occupancy actual=%0d expected=0", occupancy); end
        checks++; if (outMnemonic !== NULL) begin failures++; $display("FAIL reset_mnemonic actual=%0d expected=%0d", outMnemonic, NULL); end
        checks++; if ({outPc, outImm, outRs1, outRs2, outRd, outIllegal} !== '0) begin failures++; $display("FAIL reset_fields actual pc=%h imm=%h rs1=%0d rs2=%0d rd=%0d ill=%0b expected all 0", outPc, outImm, outRs1, outRs2, outRd, outIllegal); end
        checks++; if (outOpcode !== 7'd0) begin failures++; $display("FAIL reset_opcode actual=%h expected=0", outOpcode); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_add();
        outReady = 1'b1; inValid = 1'b1; inInstr = 32'h002081B3; inPc = 32'h100;
        tick();
        inValid = 1'b0;
        checks++; if (outValid !== 1'b1) begin failures++; $display("FAIL add_valid actual=%0b expected=1", outValid); end
        checks++; if (outMnemonic !== ADD) begin failures++; $display("FAIL add_mnemonic actual=%0d expected=%0d", outMnemonic, ADD); end
        checks++; if ({outRs1, outRs2, outRd} !== {5'd1, 5'd2, 5'd3}) begin failures++; $display("FAIL add_regs actual rs1=%0d rs2=%0d rd=%0d expected 1 2 3", outRs1, outRs2, outRd); end
        checks++; if (outImm !== 32'h0) begin failures++; $display("FAIL add_imm actual=%h expected=0", outImm); end
        checks++; if (outIllegal !== 1'b0) begin failures++; $display("FAIL add_illegal actual=%0b expected=0", outIllegal); end
        checks++; if (outPc !== 32'h100) begin failures++; $display("FAIL add_pc actual=%h expected=100", outPc); end
        checks++; if (outOpcode !== 7'b0110011) begin failures++; $display("FAIL add_opcode actual=%h expected=33", outOpcode); end
        tick();
        checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL add_pop_occupancy actual=%0d expected=0", occupancy); end
        checks++; if (outValid !== 1'b0) begin failures++; $display("FAIL add_pop_valid actual=%0b expected=0", outValid); end
    endtask

    task automatic test_fill_and_drain();
        outReady = 1'b0; inValid = 1'b1; inInstr = 32'hFFF00093; inPc = 32'h200;
        tick();
        inInstr = 32'hFE208EE3; inPc = 32'h204;
        tick();
        checks++; if (occupancy !== 2'd2) begin failures++; $display("FAIL fill_occupancy actual=%0d expected=2", occupancy); end
        checks++; if (inReady !== 1'b0) begin failures++; $display("FAIL fill_in_ready actual=%0b expected=0", inReady); end
        // third push is offered but must be held off
        inInstr = 32'h002081B3; inPc = 32'h208;
        tick();
        inValid = 1'b0;
        checks++; if (occupancy !== 2'd2) begin failures++; $display("FAIL held_occupancy actual=%0d expected=2", occupancy); end
        checks++; if (outMnemonic !== ADDI) begin failures++; $display("FAIL head_mnemonic actual=%0d expected=%0d", outMnemonic, ADDI); end
        checks++; if ({outRs1, outRs2, outRd} !== {5'd0, 5'd0, 5'd1}) begin failures++; $display("FAIL head_regs actual rs1=%0d rs2=%0d rd=%0d expected 0 0 1", outRs1, outRs2, outRd); end
        checks++; if (outImm !== 32'hFFFFFFFF) begin failures++; $display("FAIL head_imm actual=%h expected=ffffffff", outImm); end
        checks++; if (outPc !== 32'h200) begin failures++; $display("FAIL head_stable_pc actual=%h expected=200", outPc); end
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
        checks++; if (occupancy !== 2'd1) begin failures++; $display("FAIL pop_occupancy actual=%0d expected=1", occupancy); end
        checks++; if (outMnemonic !== BEQ) begin failures++; $display("FAIL beq_mnemonic actual=%0d expected=%0d", outMnemonic, BEQ); end
        checks++; if ({outRs1, outRs2, outRd} !== {5'd1, 5'd2, 5'd0}) begin failures++; $display("FAIL beq_regs actual rs1=%0d rs2=%0d rd=%0d expected 1 2 0", outRs1, outRs2, outRd); end
        checks++; if (outImm !== 32'hFFFFFFFC) begin failures++; $display("FAIL beq_imm actual=%h expected=fffffffc", outImm); end
        checks++; if (outPc !== 32'h204) begin failures++; $display("FAIL beq_pc actual=%h expected=204", outPc); end
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
        checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL drain_occupancy actual=%0d expected=0", occupancy); end
    endtask

    task automatic test_mul();
        outReady = 1'b0; inValid = 1'b1; inInstr = 32'h022081B3; inPc = 32'h300;
        tick();
        inValid = 1'b0;
        checks++; if (outMnemonic !== MUL) begin failures++; $display("FAIL mul_mnemonic actual=%0d expected=%0d", outMnemonic, MUL); end
        checks++; if ({outRs1, outRs2, outRd, outIllegal} !== {5'd1, 5'd2, 5'd3, 1'b0}) begin failures++; $display("FAIL mul_fields actual rs1=%0d rs2=%0d rd=%0d ill=%0b expected 1 2 3 0", outRs1, outRs2, outRd, outIllegal); end
        checks++; if (nomIllegal !== 1'b1) begin failures++; $display("FAIL nom_illegal actual=%0b expected=1", nomIllegal); end
        checks++; if (nomMnemonic !== NULL) begin failures++; $display("FAIL nom_mnemonic actual=%0d expected=%0d", nomMnemonic, NULL); end
        checks++; if ({nomRs1, nomRs2, nomRd, nomImm} !== '0) begin failures++; $display("FAIL nom_fields actual rs1=%0d rs2=%0d rd=%0d imm=%h expected 0", nomRs1, nomRs2, nomRd, nomImm); end
        checks++; if (nomOpcode !== 7'b0110011 || nomOutPc !== 32'h300) begin failures++; $display("FAIL nom_kept actual opc=%h pc=%h expected 33 300", nomOpcode, nomOutPc); end
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
        checks++; if (occupancy !== 2'd0 || nomOccupancy !== 2'd0) begin failures++; $display("FAIL mul_drain actual=%0d/%0d expected=0/0", occupancy, nomOccupancy); end
    endtask

    task automatic test_decode_table();
        logic [31:0]                 vInstr [8];
        RV32I_INSTRUCTION_MNEMONIC_t vMn    [8];
        logic [14:0]                 vRegs  [8];
        logic [31:0]                 vImm   [8];
        logic [31:0]                 pc;
        vInstr = '{32'h00000000, 32'h40109093, 32'h00200073, 32'h00100073,
                   32'h123450B7, 32'h8000006F, 32'h0020A223, 32'h4020D193};
        vMn    = '{NULL, NULL, NULL, EBREAK, LUI, JAL, SW, SRAI};
        vRegs  = '{15'd0, 15'd0, 15'd0, 15'd0,
                   {5'd0, 5'd0, 5'd1}, {5'd0, 5'd0, 5'd0},
                   {5'd1, 5'd2, 5'd0}, {5'd1, 5'd0, 5'd3}};
        vImm   = '{32'h0, 32'h0, 32'h0, 32'h1,
                   32'h12345000, 32'hFFF00000, 32'h4, 32'h402};
        for (int i = 0; i < 8; i++) begin
            pc = 32'h1000 + 32'(i) * 4;
            outReady = 1'b0; inValid = 1'b1; inInstr = vInstr[i]; inPc = pc;
            tick();
            inValid = 1'b0;
            checks++; if (outIllegal !== (vMn[i] == NULL)) begin failures++; $display("FAIL tbl%0d_illegal actual=%0b expected=%0b", i, outIllegal, (vMn[i] == NULL)); end
            checks++; if (outMnemonic !== vMn[i]) begin failures++; $display("FAIL tbl%0d_mnemonic actual=%0d expected=%0d", i, outMnemonic, vMn[i]); end
            checks++; if ({outRs1, outRs2, outRd} !== vRegs[i]) begin failures++; $display("FAIL tbl%0d_regs actual=%h expected=%h", i, {outRs1, outRs2, outRd}, vRegs[i]); end
            checks++; if (outImm !== vImm[i]) begin failures++; $display("FAIL tbl%0d_imm actual=%h expected=%h", i, outImm, vImm[i]); end
            checks++; if (outOpcode !== vInstr[i][6:0] || outPc !== pc) begin failures++; $display("FAIL tbl%0d_opc_pc actual opc=%h pc=%h expected %h %h", i, outOpcode, outPc, vInstr[i][6:0], pc); end
            outReady = 1'b1;
            tick();
        end
        outReady = 1'b0;
    endtask

    task automatic test_back_to_back();
        outReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            inValid = 1'b1; inInstr = 32'h002081B3; inPc = 32'h400 + 32'(i) * 4;
            tick();
            checks++; if (outValid !== 1'b1 || outPc !== 32'h400 + 32'(i) * 4 || occupancy !== 2'd1) begin failures++; $display("FAIL b2b%0d actual valid=%0b pc=%h occ=%0d expected 1 %h 1", i, outValid, outPc, occupancy, 32'h400 + 32'(i) * 4); end
        end
        inValid = 1'b0;
        tick();
        checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL b2b_drain actual=%0d expected=0", occupancy); end
        outReady = 1'b0;
    endtask

    task automatic test_flush();
        outReady = 1'b0; inValid = 1'b1; inInstr = 32'h002081B3; inPc = 32'h500;
        tick();
        inPc = 32'h504;
        tick();
        checks++; if (occupancy !== 2'd2) begin failures++; $display("FAIL flush_prefill actual=%0d expected=2", occupancy); end
        flush = 1'b1; inInstr = 32'h00100073; inPc = 32'h508;
        tick();
        flush = 1'b0; inValid = 1'b0;
        checks++; if (occupancy !== 2'd0 || outValid !== 1'b0) begin failures++; $display("FAIL flush_full actual occ=%0d valid=%0b expected 0 0", occupancy, outValid); end
        checks++; if (inReady !== 1'b1) begin failures++; $display("FAIL flush_in_ready actual=%0b expected=1", inReady); end
        // one entry held, so the push in the flush cycle really is offered
        inValid = 1'b1; inInstr = 32'h002081B3; inPc = 32'h600;
        tick();
        flush = 1'b1; inInstr = 32'h00100073; inPc = 32'h604;
        tick();
        flush = 1'b0; inValid = 1'b0;
        checks++; if (occupancy !== 2'd0 || outValid !== 1'b0) begin failures++; $display("FAIL flush_push actual occ=%0d valid=%0b expected 0 0", occupancy, outValid); end
        tick();
        checks++; if (outValid !== 1'b0 || outMnemonic !== NULL) begin failures++; $display("FAIL flush_dropped actual valid=%0b mn=%0d expected 0 %0d", outValid, outMnemonic, NULL); end
    endtask

    task automatic test_async_reset();
        outReady = 1'b0; inValid = 1'b1; inInstr = 32'h002081B3; inPc = 32'h700;
        tick();
        inValid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++; if (outValid !== 1'b0 || occupancy !== 2'd0 || inReady !== 1'b1) begin failures++; $display("FAIL async_reset actual valid=%0b occ=%0d rdy=%0b expected 0 0 1", outValid, occupancy, inReady); end
        checks++; if (outPc !== 32'h0 || outMnemonic !== NULL) begin failures++; $display("FAIL async_reset_fields actual pc=%h mn=%0d expected 0 %0d", outPc, outMnemonic, NULL); end
        tick();
        rst = 1'b0;
        tick();
        checks++; if (outValid !== 1'b0) begin failures++; $display("FAIL async_reset_lost actual=%0b expected=0", outValid); end
    endtask

    // Run every scenario in order, then report
    initial begin
        $display("[TB] starting rv_decode_stage bench");
        test_reset();
        test_add();
        test_fill_and_drain();
        test_mul();
        test_decode_table();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
